// File: rtl/hilo_issue_ctrl.sv
// HI/LO issue controller: issues MULT/DIV work to the multiply/divide unit, captures its result into HI/LO.
// Defining HILO_TIMEOUT_EN adds a watchdog on the unit's busy handshake (sticky timeout_err).
module hilo_issue_ctrl #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_op,
    input  logic [DATA_W-1:0]   rs_val,
    input  logic [DATA_W-1:0]   rt_val,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                enable,
    output logic [DATA_W-1:0]   value_1,
    output logic [DATA_W-1:0]   value_2,
    output logic [1:0]          operation,
    input  logic [2*DATA_W-1:0] out,
    input  logic                in_operation,
    output logic                timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        BUSY,
        CAPTURE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              accept;
    logic              is_arith;
    logic              timeout_hit;

    assign req_ready = (state == IDLE) && rst_n;
    assign accept    = req_valid && req_ready;
    assign is_arith  = ~req_op[2];

`ifdef HILO_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;

    assign waiting     = (state == WAIT_START) || (state == BUSY);
    assign timeout_hit = waiting && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // A result arriving on the last allowed cycle still wins over the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt <= waiting ? wait_cnt + CNT_W'(1) : '0;
            if (timeout_hit && (state_nxt == IDLE)) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept && is_arith) begin
                    state_nxt = WAIT_START;
                end
            end
            WAIT_START: begin
                if (timeout_hit) begin
                    state_nxt = IDLE;
                end else if (in_operation) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!in_operation) begin
                    state_nxt = CAPTURE;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            CAPTURE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Requests are only accepted in IDLE, so HI/LO writes from MTHI/MTLO never collide with CAPTURE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi        <= '0;
            lo        <= '0;
            enable    <= 1'b0;
            value_1   <= '0;
            value_2   <= '0;
            operation <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            enable   <= accept && is_arith;
            rd_valid <= accept && (req_op[2:1] == 2'b11);
            if (accept) begin
                case (req_op)
                    3'd4: hi      <= rs_val;
                    3'd5: lo      <= rs_val;
                    3'd6: rd_data <= hi;
                    3'd7: rd_data <= lo;
                    default: begin
                        value_1   <= rs_val;
                        value_2   <= rt_val;
                        operation <= req_op[1:0];
                    end
                endcase
            end
            if (state == CAPTURE) begin
                hi <= out[2*DATA_W-1:DATA_W];
                lo <= out[DATA_W-1:0];
            end
        end
    end

endmodule
